adder_serial_reduce: RTL and testbench



---
 rtl/adder_serial_reduce.sv | 100 ++++++++++
 tb/tb_adder_serial_reduce.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_reduce.sv
// adder_serial_reduce: reduces n packed operands with one adder over n cycles; ADDER_SERIAL_SIGNED_EN selects two's-complement operands
module adder_serial_reduce #(
    parameter int n     = 4,
    parameter int width = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [n*width-1:0]        add,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(n)+width-1:0] sum,
    output logic                      busy
);
    localparam int AW = $clog2(n) + width;
    localparam int CW = n > 1 ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [n*width-1:0] op_q, op_d;
    logic [AW-1:0]      acc_q, acc_d, sum_q, sum_d, ext;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [width-1:0]   elem;
    logic               last;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign busy      = state_q == ACCUM;
    assign sum       = sum_q;
    assign out_valid = out_valid_q;
    assign elem      = op_q[int'(cnt_q)*width +: width];
    assign last      = cnt_q == CW'(n - 1);
`ifdef ADDER_SERIAL_SIGNED_EN
    assign ext = AW'($signed(elem));
`else
    assign ext = AW'(elem);
`endif

    // next-state: capture on accept, one addition per ACCUM cycle, publish on the n-th
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = add;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ext;
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    sum_d       = acc_q + ext;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? ACCUM : IDLE;
                    if (in_valid) begin
                        op_d  = add;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset drops any partial sum immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_adder_serial_reduce.sv
// tb_adder_serial_reduce: randomized check of the serial reducer against an arithmetic sum model
module tb_adder_serial_reduce;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = $clog2(N) + W;

    logic clk = 0, rst_n = 0;
    logic a_iv = 0, a_ir, a_ov, a_or = 0, a_busy;
    logic [N*W-1:0] a_add = '0;
    logic [AW-1:0] a_sum;
    logic b_iv = 0, b_ir, b_ov, b_or = 0, b_busy;
    logic [23:0] b_add = '0;
    logic [9:0] b_sum;
    logic c_iv = 0, c_ir, c_ov, c_or = 0, c_busy;
    logic [7:0] c_add = '0;
    logic [7:0] c_sum;
    int errors = 0, checks = 0;

    adder_serial_reduce #(.n(N), .width(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .add(a_add),
        .out_valid(a_ov), .out_ready(a_or), .sum(a_sum), .busy(a_busy));
    adder_serial_reduce #(.n(3), .width(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .add(b_add),
        .out_valid(b_ov), .out_ready(b_or), .sum(b_sum), .busy(b_busy));
    adder_serial_reduce #(.n(1), .width(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .add(c_add),
        .out_valid(c_ov), .out_ready(c_or), .sum(c_sum), .busy(c_busy));

    always #5 clk = ~clk;

    // sum of all elements as plain integers, wrapped to the output width
    function automatic longint model(input logic [63:0] v, input int nn, input int w);
        longint s = 0;
        int aw = $clog2(nn) + w;
        for (int i = 0; i < nn; i++) begin
            longint e = longint'((v >> (i * w)) & ((64'd1 << w) - 1));
`ifdef ADDER_SERIAL_SIGNED_EN
            if (((e >> (w - 1)) & 1) != 0) e = e - (longint'(1) << w);
`endif
            s = s + e;
        end
        return s & ((longint'(1) << aw) - 1);
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] v);
        chk("accept_ready", a_ir, 1);
        a_add = v;
        a_iv  = 1;
        tick();
        a_iv  = 0;
        a_add = $urandom;
    endtask

    task automatic observe(input longint exp);
        for (int k = 0; k < N; k++) begin
            chk("accum_busy", a_busy, 1);
            chk("accum_ready", a_ir, 0);
            chk("accum_ov", a_ov, 0);
            a_iv  = (k < N - 1) ? 1'($urandom) : 1'b0;
            a_or  = (k < N - 1) ? 1'($urandom) : 1'b0;
            a_add = $urandom;
            tick();
        end
        chk("done_ov", a_ov, 1);
        chk("done_sum", a_sum, exp);
        chk("done_busy", a_busy, 0);
        chk("done_ready", a_ir, 0);
    endtask

    task automatic hold(input int cyc, input longint exp);
        repeat (cyc) begin
            a_iv  = 1'($urandom);
            a_add = $urandom;
            tick();
            chk("hold_ov", a_ov, 1);
            chk("hold_sum", a_sum, exp);
            chk("hold_ready", a_ir, 0);
        end
        a_iv = 0;
    endtask

    task automatic consume(input longint exp);
        a_iv = 0;
        a_or = 1;
        #1;
        chk("consume_ready", a_ir, 1);
        tick();
        a_or = 0;
        chk("consume_ov", a_ov, 0);
        chk("consume_sum_kept", a_sum, exp);
        chk("idle_ready", a_ir, 1);
        chk("idle_busy", a_busy, 0);
    endtask

    task automatic b2b(input logic [31:0] v);
        a_or  = 1;
        a_iv  = 1;
        a_add = v;
        #1;
        chk("b2b_ready", a_ir, 1);
        tick();
        a_or = 0;
        a_iv = 0;
        a_add = $urandom;
    endtask

    initial begin
        logic [31:0] v;
        longint prev = 0;
        bit in_done = 0;
        #1;
        chk("rst_sum", a_sum, 0);
        chk("rst_ov", a_ov, 0);
        chk("rst_busy", a_busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        tick();
        chk("rst_ready", a_ir, 1);

        accept(32'h04030201);
        observe(10'h00A);
        hold(10, 10'h00A);
        consume(10'h00A);

        accept(32'hFFFFFFFF);
        observe(10'h3FC);
        b2b(32'h10101010);
        observe(10'h040);
        consume(10'h040);

        accept(32'h008001FF);
`ifdef ADDER_SERIAL_SIGNED_EN
        observe(10'h380);
`else
        observe(10'h180);
`endif
        consume(model(64'h008001FF, N, W));

        for (int r = 0; r < 20; r++) begin
            v = $urandom;
            if (in_done && $urandom_range(0, 1) == 1) b2b(v);
            else begin
                if (in_done) consume(prev);
                accept(v);
            end
            prev = model(64'(v), N, W);
            observe(prev);
            hold($urandom_range(0, 3), prev);
            in_done = 1;
        end
        consume(prev);

        accept(32'h05050505);
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        chk("midrst_ov", a_ov, 0);
        chk("midrst_sum", a_sum, 0);
        chk("midrst_busy", a_busy, 0);
        @(negedge clk) rst_n = 1;
        repeat (N + 2) begin
            tick();
            chk("postrst_ov", a_ov, 0);
            chk("postrst_ready", a_ir, 1);
        end

        for (int r = 0; r < 5; r++) begin
            b_add = (r == 0) ? 24'h0A0B0C : 24'($urandom);
            b_iv  = 1;
            tick();
            b_iv  = 0;
            chk("n3_busy", b_busy, 1);
            tick();
            tick();
            chk("n3_early_ov", b_ov, 0);
            tick();
            chk("n3_ov", b_ov, 1);
            chk("n3_sum", b_sum, (r == 0) ? 10'h021 : model(64'(b_add), 3, 8));
            b_or = 1;
            tick();
            b_or = 0;
            chk("n3_consume", b_ov, 0);
        end

        for (int r = 0; r < 5; r++) begin
            c_add = (r == 0) ? 8'hAB : 8'($urandom);
            c_iv  = 1;
            tick();
            c_iv  = 0;
            chk("n1_early_ov", c_ov, 0);
            tick();
            chk("n1_ov", c_ov, 1);
            chk("n1_sum", c_sum, (r == 0) ? 8'hAB : model(64'(c_add), 1, 8));
            c_or = 1;
            tick();
            c_or = 0;
            chk("n1_consume", c_ov, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
